freq_meter: RTL
===============

# freq_meter

Measures the period and high time of a slow, clk-synchronous periodic signal, such as the output of our clock dividers, in units of `clk` cycles. It is the checking end of the divider chain: it sits after `freq_div_*` outputs (or any strobe source) in self-test and clock-monitor paths. It reports each completed period, declares lock after a run of identical periods, and flags loss of signal on timeout.

## Interface
Parameters:
- `CNT_W`, 8, width of the cycle counters and of the `period`/`high_time` outputs.
- `LOCK_N`, 4, number of consecutive identical periods required to assert `locked`. Legal range 1..15.
- `TIMEOUT`, 255, cycle count without a rising edge that aborts the measurement. Must satisfy 2 ≤ `TIMEOUT` ≤ 2^`CNT_W`−1.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `sig_in`  in  1  measured signal, already synchronous to `clk`.
- `period`  out  `CNT_W`  cycles between the last two rising edges.
- `high_time`  out  `CNT_W`  cycles `sig_in` was high within that period.
- `valid`  out  1  one-cycle pulse when `period`/`high_time` update.
- `locked`  out  1  `LOCK_N` consecutive equal periods seen.
- `timeout`  out  1  no rising edge for `TIMEOUT` cycles; sticky until the next rising edge.

## Operation
- `s_q` holds the previous-cycle sample of `sig_in`. `rise = sig_in & ~s_q`.
- State IDLE: waits for a rise. On a rise, load `cnt` = 1 and `hcnt` = 1, clear `timeout`, and go to MEAS. No `valid` is produced.
- State MEAS, cycle with no rise:
  - `cnt` increments.
  - `hcnt` increments if `sig_in` = 1.
  - If `cnt` == `TIMEOUT`: go to IDLE, set `timeout` = 1, clear `locked` and the run counter. `period` and `high_time` hold their values.
- State MEAS, cycle with a rise:
  - `period` ← `cnt`, `high_time` ← `hcnt`, `valid` ← 1.
  - Reload `cnt` = 1 and `hcnt` = 1. Stay in MEAS.
- Run counter `run` (4 bits):
  - First measurement after IDLE: `run` = 1.
  - New period equals the previous `period`: `run` increments, saturating at `LOCK_N`.
  - Otherwise: `run` = 1.
  - `locked` = (`run` ≥ `LOCK_N`), registered and updated in the same cycle as `valid`.
- Rise and `cnt` == `TIMEOUT` in the same cycle: the rise wins. `period` = `TIMEOUT`, `valid` pulses, no timeout.
- `cnt` never exceeds `TIMEOUT`, so no wrap is possible. `hcnt` ≤ `cnt` always.

## Timing
- Reset values:
  - state IDLE; `s_q` = 1, so a level held high across reset is not a rise.
  - `cnt`, `hcnt`, `run` = 0.
  - `period`, `high_time` = 0; `valid`, `locked`, `timeout` = 0.
- `rst` dominates all other inputs. Asserting it mid-measurement discards the partial count; the first `valid` after reset requires two rises.
- Latency: `valid`, `period`, `high_time` and `locked` are visible in the cycle after the clock edge at which the rise is sampled.
- `valid` is high for exactly one cycle per measured period and is never high in consecutive cycles unless `period` = 1. `period` = 1 cannot occur for a single-bit input, so back-to-back `valid` never happens.
- `timeout` rises in the cycle after the edge at which `cnt` == `TIMEOUT` is sampled. It falls in the cycle after the next rise.

## Structure
- Shared package `freq_pkg` holds:
  - the state encoding constants (`ST_IDLE`, `ST_MEAS`);
  - default `CNT_W`/`TIMEOUT` constants, reused by the divider blocks' testbenches.
- One natural sub-module, `edge_det`: the `s_q` register plus the rise output, reset value 1. The FSM, counters and lock logic stay in `freq_meter`.

## Test plan
- Divide-by-10 source, 4 high / 6 low → first `valid` at the second rise with `period` = 10, `high_time` = 4. `locked` = 1 on the 4th `valid`, and stays 1.
- Period sequence 10,10,10,9,10 → `locked` never asserts, and `run` restarts at 1 after the 9. Four further periods of 10 → `locked` = 1.
- `sig_in` held low after one rise, `TIMEOUT` = 20 → `timeout` = 1 in the cycle after `cnt` reaches 20. `locked` = 0, and `period` retains its old value. The next rise clears `timeout` with no `valid`.
- Rise arriving exactly when `cnt` == `TIMEOUT` → `valid` with `period` = `TIMEOUT`, `timeout` stays 0.
- `rst` pulsed mid-period while `locked` = 1 → all outputs 0 the next cycle. `sig_in` high across reset produces no rise.
- `sig_in` constant 1 from reset → no `valid`, and no `timeout` because the FSM never leaves IDLE.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared constants for the frequency-measurement blocks: FSM encoding and
// default counter sizing reused by the divider benches.
package freq_pkg;

    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned RUN_W       = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

endpackage

// File: rtl/freq_meter_edge_det.sv
// Rising-edge detector on an already-synchronous input. The history register
// resets high so a level held across reset does not look like an edge.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise_c
);

    logic s_q;

    always_ff @(posedge clk) begin
        if (rst) s_q <= 1'b1;
        else     s_q <= sig_in;
    end

    assign rise_c = sig_in & ~s_q;

endmodule

// File: rtl/freq_meter.sv
// Period / high-time meter for a slow clk-synchronous strobe, with lock
// detection over consecutive equal periods and a loss-of-signal timeout.
module freq_meter
    import freq_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned LOCK_N  = 4,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] period_d, high_time_d;
    logic             valid_d, locked_d, timeout_d;
    logic             rise_c;

    edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise_c (rise_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            run_q     <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            run_q     <= run_d;
            period    <= period_d;
            high_time <= high_time_d;
            valid     <= valid_d;
            locked    <= locked_d;
            timeout   <= timeout_d;
        end
    end

    // A rise always closes the current period, even when cnt has just reached
    // TIMEOUT; run_q == 0 marks the first measurement after IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        run_d       = run_q;
        period_d    = period;
        high_time_d = high_time;
        valid_d     = 1'b0;
        locked_d    = locked;
        timeout_d   = timeout;
        case (state_q)
            ST_IDLE: begin
                if (rise_c) begin
                    cnt_d     = CNT_W'(1);
                    hcnt_d    = CNT_W'(1);
                    timeout_d = 1'b0;
                    state_d   = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (rise_c) begin
                    period_d    = cnt_q;
                    high_time_d = hcnt_q;
                    valid_d     = 1'b1;
                    cnt_d       = CNT_W'(1);
                    hcnt_d      = CNT_W'(1);
                    if (run_q == '0 || cnt_q != period)
                        run_d = RUN_W'(1);
                    else if (run_q < RUN_W'(LOCK_N))
                        run_d = run_q + RUN_W'(1);
                    locked_d = (run_d >= RUN_W'(LOCK_N));
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    run_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sig_in) hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
